demux_3w_1_to_5_reg: RTL and testbench
======================================

Name: demux_3w_1_to_5_reg

Overview:
- Registered 1-to-5 distributor for 3-bit data. It is the write-side counterpart of the 5-lane selector: one data stream is steered into five lane registers U, V, W, X and Y.
- Lane choice comes either from an external select (S) or from an internal round-robin counter.
- Each lane has a valid/acknowledge handshake so a downstream consumer can drain it.

Parameters:
- WIDTH, 3, data width of D and of each lane register.
- LANES, 5, number of output lanes. Fixed; the select encoding assumes 5.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- D  input  WIDTH  data to distribute.
- S  input  3  lane select in manual mode: 0=U, 1=V, 2=W, 3=X, 4=Y; 5-7 are illegal.
- En  input  1  write strobe; D is captured on the edge where En=1.
- Auto  input  1  1 = lane taken from the internal counter; 0 = lane taken from S.
- Ack  input  5  per-lane consumer acknowledge; bit0=U … bit4=Y.
- U, V, W, X, Y  output  WIDTH each  lane holding registers.
- Valid  output  5  per-lane "holds unconsumed data" flags.
- Lane  output  3  current round-robin counter value, 0-4.
- Frame  output  1  one-cycle pulse after an auto-mode write to lane 4.
- Err  output  1  sticky flag set by a manual-mode write with illegal S.

Behaviour:
- Reset (sampled on a Clk edge with Reset=1):
  - U..Y=0, Valid=0, Lane=0, Frame=0, Err=0.
  - Reset overrides En, Ack and Auto in that cycle.
- Latency: all outputs are registered and reflect a write one cycle after the En edge. No combinational path from inputs to outputs.
- Target lane on an edge with En=1:
  - Auto=0: target = S.
  - Auto=1: target = Lane; S is ignored.
- Write to a legal target:
  - The lane register loads D and its Valid bit sets to 1.
  - Other lanes hold their values.
  - A lane is overwritten even if its Valid bit is already 1; the old data is lost and no error is raised.
- Illegal manual write (Auto=0, S in 5-7):
  - No lane register or Valid bit changes.
  - Err is set to 1 and stays set until Reset.
- Round-robin counter (Lane):
  - Advances only on an edge with En=1 and Auto=1, sequence 0,1,2,3,4,0,…; wraps 4→0.
  - Holds its value while Auto=0 or En=0. Switching Auto mid-sequence resumes from the held value.
- Frame:
  - 1 for exactly one cycle following an auto-mode write to lane 4; otherwise 0.
  - Back-to-back frames give isolated pulses every fifth write.
- Ack:
  - Ack[i]=1 on an edge clears Valid[i]; the lane data register is unchanged.
  - Ack on a lane whose Valid is already 0 has no effect.
  - Multiple Ack bits may be set in the same cycle.
- Write and Ack to the same lane in the same cycle: the write wins, Valid[i] ends at 1 and the data is new.
- Write and Ack to different lanes in the same cycle: both take effect.
- En=0: no lane, Valid or Lane change; Ack still operates.
- Reset mid-sequence: Lane returns to 0, so the next auto write goes to U.

Test Plan:
- Reset, then manual writes with Auto=0, En=1 pulsed once each: S=0 D=5, S=2 D=3, S=4 D=7 -> next cycles show U=5, W=3, Y=7, Valid=5'b10101, V=X=0, Err=0.
- Auto round-robin: Auto=1, En=1 for 6 cycles with D=1,2,3,4,5,6:
  - Lane steps 0,1,2,3,4,0.
  - Ends with U=6, V=2, W=3, X=4, Y=5, Valid=5'b11111.
  - Frame=1 only in the cycle after D=5 is written.
- Illegal select: Auto=0, S=6, D=7, En=1 -> all lanes and Valid unchanged, Err=1. Err stays 1 across later legal writes until Reset.
- Handshake collision:
  - Setup: U holds 2 with Valid[0]=1.
  - Stimulus: same cycle S=0, D=4, En=1, Ack=5'b00001, plus Ack[1]=1 with V valid.
  - Required: U=4, Valid[0]=1, Valid[1]=0.
- Auto/manual interleave plus reset:
  - Setup: auto-write 2 values (Lane=2); switch to Auto=0 and write S=4, D=1; return to Auto=1 and write D=6.
  - Required before reset: Y=1, W=6, Lane=3.
  - Then assert Reset mid-stream -> all outputs 0, and the next auto write lands in U.

Source files
------------

// File: rtl/demux_3w_1_to_5_reg.sv
// demux_3w_1_to_5_reg
//   Registered 1-to-5 distributor. One WIDTH-bit data stream is steered into
//   five lane holding registers (U, V, W, X, Y). The target lane comes either
//   from the external select S (manual mode) or from an internal round-robin
//   counter (auto mode). Each lane has a valid flag that a downstream consumer
//   clears through its Ack bit.
//
//   Ports:
//     Clk    in   rising-edge clock
//     Reset  in   synchronous, active-high reset
//     D      in   data to distribute
//     S      in   manual lane select (0=U .. 4=Y, 5-7 illegal)
//     En     in   write strobe
//     Auto   in   1 = lane from round-robin counter, 0 = lane from S
//     Ack    in   per-lane consumer acknowledge (bit0=U .. bit4=Y)
//     U..Y   out  lane holding registers
//     Valid  out  per-lane "holds unconsumed data" flags
//     Lane   out  round-robin counter value (0-4)
//     Frame  out  one-cycle pulse after an auto-mode write to lane 4
//     Err    out  sticky flag, set by a manual write with illegal S

module demux_3w_1_to_5_reg #(
    parameter int WIDTH = 3,
    parameter int LANES = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    input  logic [2:0]       S,
    input  logic             En,
    input  logic             Auto,
    input  logic [LANES-1:0] Ack,
    output logic [WIDTH-1:0] U,
    output logic [WIDTH-1:0] V,
    output logic [WIDTH-1:0] W,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [LANES-1:0] Valid,
    output logic [2:0]       Lane,
    output logic             Frame,
    output logic             Err
);

    logic [WIDTH-1:0] lane_q [LANES];
    logic [2:0]       target;
    logic [LANES-1:0] wr_hit;
    logic             illegal_wr;
    logic             auto_wr;

    always_comb begin
        target = Auto ? Lane : S;
        wr_hit = '0;
        // An out-of-range target matches no lane, so illegal writes drop out here.
        for (int unsigned i = 0; i < LANES; i++) begin
            wr_hit[i] = En && (target == 3'(i));
        end
        illegal_wr = En && !Auto && (S >= 3'(LANES));
        auto_wr    = En && Auto;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
            Valid <= '0;
            Lane  <= '0;
            Frame <= 1'b0;
            Err   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wr_hit[i]) begin
                    lane_q[i] <= D;
                end
            end
            // Ack clears first, then a write to the same lane sets it again.
            Valid <= (Valid & ~Ack) | wr_hit;

            if (auto_wr) begin
                Lane <= (Lane == 3'(LANES - 1)) ? '0 : Lane + 3'd1;
            end
            Frame <= auto_wr && (Lane == 3'(LANES - 1));

            if (illegal_wr) begin
                Err <= 1'b1;
            end
        end
    end

    assign U = lane_q[0];
    assign V = lane_q[1];
    assign W = lane_q[2];
    assign X = lane_q[3];
    assign Y = lane_q[4];

endmodule

// File: tb/tb_demux_3w_1_to_5_reg.sv
// tb_demux_3w_1_to_5_reg
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model of the distributor kept in plain arrays.

module tb_demux_3w_1_to_5_reg;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] D;
    logic [2:0] S;
    logic       En;
    logic       Auto;
    logic [4:0] Ack;
    logic [2:0] U, V, W, X, Y;
    logic [4:0] Valid;
    logic [2:0] Lane;
    logic       Frame;
    logic       Err;

    demux_3w_1_to_5_reg #(.WIDTH(3), .LANES(5)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .D     (D),
        .S     (S),
        .En    (En),
        .Auto  (Auto),
        .Ack   (Ack),
        .U     (U),
        .V     (V),
        .W     (W),
        .X     (X),
        .Y     (Y),
        .Valid (Valid),
        .Lane  (Lane),
        .Frame (Frame),
        .Err   (Err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_data  [5];
    bit m_valid [5];
    int m_lane;
    bit m_frame;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input int d, input int s, input bit en,
                              input bit au, input logic [4:0] ack);
        int t;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                m_data[i]  = 0;
                m_valid[i] = 0;
            end
            m_lane  = 0;
            m_frame = 0;
            m_err   = 0;
            return;
        end
        m_frame = 0;
        for (int i = 0; i < 5; i++) begin
            if (ack[i]) m_valid[i] = 0;
        end
        if (en) begin
            t = au ? m_lane : s;
            if (t < 5) begin
                m_data[t]  = d;
                m_valid[t] = 1;
            end else begin
                m_err = 1;
            end
            if (au) begin
                m_frame = (m_lane == 4);
                m_lane  = (m_lane + 1) % 5;
            end
        end
    endtask

    function automatic logic [31:0] model_valid();
        logic [31:0] v = 0;
        for (int i = 0; i < 5; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic compare_all();
        check("U", 32'(U), 32'(m_data[0]));
        check("V", 32'(V), 32'(m_data[1]));
        check("W", 32'(W), 32'(m_data[2]));
        check("X", 32'(X), 32'(m_data[3]));
        check("Y", 32'(Y), 32'(m_data[4]));
        check("Valid", 32'(Valid), model_valid());
        check("Lane", 32'(Lane), 32'(m_lane));
        check("Frame", 32'(Frame), 32'(m_frame));
        check("Err", 32'(Err), 32'(m_err));
    endtask

    // Apply one cycle of inputs, step the model, compare after the edge.
    task automatic cycle(input bit rst, input int d, input int s, input bit en,
                         input bit au, input logic [4:0] ack);
        Reset = rst;
        D     = 3'(d);
        S     = 3'(s);
        En    = en;
        Auto  = au;
        Ack   = ack;
        @(posedge Clk);
        model_step(rst, d, s, en, au, ack);
        #1;
        compare_all();
    endtask

    initial begin
        Reset = 1'b1; D = '0; S = '0; En = 1'b0; Auto = 1'b0; Ack = '0;

        // Reset state
        cycle(1, 0, 0, 0, 0, 5'b00000);
        check("rst_valid", 32'(Valid), 32'h0);
        check("rst_lane", 32'(Lane), 32'h0);

        // Manual writes
        cycle(0, 5, 0, 1, 0, 5'b00000);
        cycle(0, 3, 2, 1, 0, 5'b00000);
        cycle(0, 7, 4, 1, 0, 5'b00000);
        check("man_U", 32'(U), 32'd5);
        check("man_W", 32'(W), 32'd3);
        check("man_Y", 32'(Y), 32'd7);
        check("man_V", 32'(V), 32'd0);
        check("man_X", 32'(X), 32'd0);
        check("man_valid", 32'(Valid), 32'b10101);
        check("man_err", 32'(Err), 32'd0);

        // Auto round-robin, D=1..6
        for (int k = 1; k <= 6; k++) begin
            cycle(0, k, 0, 1, 1, 5'b00000);
            check("rr_lane", 32'(Lane), 32'(k % 5));
            check("rr_frame", 32'(Frame), (k == 5) ? 32'd1 : 32'd0);
        end
        check("rr_U", 32'(U), 32'd6);
        check("rr_V", 32'(V), 32'd2);
        check("rr_W", 32'(W), 32'd3);
        check("rr_X", 32'(X), 32'd4);
        check("rr_Y", 32'(Y), 32'd5);
        check("rr_valid", 32'(Valid), 32'b11111);

        // Illegal select, Err sticky across a later legal write
        cycle(0, 7, 6, 1, 0, 5'b00000);
        check("ill_err", 32'(Err), 32'd1);
        check("ill_U", 32'(U), 32'd6);
        check("ill_valid", 32'(Valid), 32'b11111);
        cycle(0, 1, 3, 1, 0, 5'b00000);
        check("ill_sticky", 32'(Err), 32'd1);
        cycle(0, 0, 0, 0, 0, 5'b00000);
        check("ill_sticky2", 32'(Err), 32'd1);

        // Handshake collision
        cycle(1, 0, 0, 0, 0, 5'b00000);
        cycle(0, 2, 0, 1, 0, 5'b00000);
        cycle(0, 1, 1, 1, 0, 5'b00000);
        cycle(0, 4, 0, 1, 0, 5'b00011);
        check("col_U", 32'(U), 32'd4);
        check("col_valid0", 32'(Valid[0]), 32'd1);
        check("col_valid1", 32'(Valid[1]), 32'd0);
        check("col_V", 32'(V), 32'd1);
        // Ack without write leaves data alone
        cycle(0, 0, 0, 0, 0, 5'b00001);
        check("ack_valid", 32'(Valid), 32'd0);
        check("ack_U", 32'(U), 32'd4);

        // Auto/manual interleave, then reset mid-stream
        cycle(1, 0, 0, 0, 0, 5'b00000);
        cycle(0, 3, 0, 1, 1, 5'b00000);
        cycle(0, 5, 0, 1, 1, 5'b00000);
        check("il_lane2", 32'(Lane), 32'd2);
        cycle(0, 1, 4, 1, 0, 5'b00000);
        check("il_lane_hold", 32'(Lane), 32'd2);
        cycle(0, 6, 7, 1, 1, 5'b00000);
        check("il_Y", 32'(Y), 32'd1);
        check("il_W", 32'(W), 32'd6);
        check("il_lane3", 32'(Lane), 32'd3);
        check("il_err", 32'(Err), 32'd0);
        cycle(1, 5, 0, 1, 1, 5'b11111);
        check("il_rst_Y", 32'(Y), 32'd0);
        check("il_rst_valid", 32'(Valid), 32'd0);
        check("il_rst_lane", 32'(Lane), 32'd0);
        cycle(0, 2, 3, 1, 1, 5'b00000);
        check("il_next_U", 32'(U), 32'd2);
        check("il_next_valid", 32'(Valid), 32'b00001);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
